// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command/parameter sequencer: FSM encoding,
// D/C line levels and the parameter-count saturation helper.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_CMD = 3'd1,
    ST_WAIT_CMD = 3'd2,
    ST_FETCH    = 3'd3,
    ST_SEND_PAR = 3'd4,
    ST_WAIT_PAR = 3'd5,
    ST_FINISH   = 3'd6
  } state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  function automatic logic [3:0] sat_count(input logic [3:0] n, input int unsigned max_n);
    return (32'(n) > max_n) ? 4'(max_n) : n;
  endfunction

endpackage

// File: rtl/lcd_cmd_seq.sv
// Sends one LCD command byte followed by up to MAX_PARAM parameter bytes to an
// SPI byte serializer, with a per-byte completion timeout.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int MAX_PARAM = 15,
  parameter int TIMEOUT   = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_cmd,
  input  logic [3:0] i_nparam,
  input  logic [7:0] i_param,
  input  logic       i_param_valid,
  output logic       o_param_ready,
  output logic [7:0] o_data,
  output logic       o_we,
  input  logic       i_done,
  output logic       o_dc,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        r_state, w_state_next;
  logic [7:0]    r_cmd, w_cmd_next;
  logic [7:0]    r_param, w_param_next;
  logic [3:0]    r_remain, w_remain_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]    r_data, w_data_next;
  logic          r_dc, w_dc_next;
  logic          r_we, w_we_next;
  logic          r_err, w_err_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cmd    <= 8'd0;
      r_param  <= 8'd0;
      r_remain <= 4'd0;
      r_cnt    <= '0;
      r_data   <= 8'd0;
      r_dc     <= DC_CMD;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cmd    <= w_cmd_next;
      r_param  <= w_param_next;
      r_remain <= w_remain_next;
      r_cnt    <= w_cnt_next;
      r_data   <= w_data_next;
      r_dc     <= w_dc_next;
      r_we     <= w_we_next;
      r_err    <= w_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cmd_next    = r_cmd;
    w_param_next  = r_param;
    w_remain_next = r_remain;
    w_cnt_next    = r_cnt;
    w_data_next   = r_data;
    w_dc_next     = r_dc;
    w_we_next     = 1'b0;
    w_err_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_cmd_next    = i_cmd;
          w_remain_next = sat_count(i_nparam, MAX_PARAM);
          w_state_next  = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        w_data_next  = r_cmd;
        w_dc_next    = DC_CMD;
        w_we_next    = 1'b1;
        w_cnt_next   = '0;
        w_state_next = ST_WAIT_CMD;
      end
      ST_FETCH: begin
        if (i_param_valid) begin
          w_param_next = i_param;
          w_state_next = ST_SEND_PAR;
        end
      end
      ST_SEND_PAR: begin
        w_data_next  = r_param;
        w_dc_next    = DC_DATA;
        w_we_next    = 1'b1;
        w_cnt_next   = '0;
        w_state_next = ST_WAIT_PAR;
      end
      ST_WAIT_CMD, ST_WAIT_PAR: begin
        // A completion arriving on the last allowed cycle still wins over the abort.
        if (i_done) begin
          if (r_state == ST_WAIT_CMD) begin
            w_state_next = (r_remain != 4'd0) ? ST_FETCH : ST_FINISH;
          end else begin
            w_remain_next = r_remain - 4'd1;
            w_state_next  = (r_remain != 4'd1) ? ST_FETCH : ST_FINISH;
          end
        end else if (r_cnt == TMO_LAST) begin
          w_err_next   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign o_data        = r_data;
  assign o_dc          = r_dc;
  assign o_we          = r_we;
  assign o_err         = r_err;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_FINISH);
  assign o_param_ready = (r_state == ST_FETCH) && i_param_valid;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq: serializer/parameter-source models plus
// an expected-byte-list reference built from the transaction request.
module tb_lcd_cmd_seq;

  localparam int MAXP = 6;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_cmd = 8'd0;
  logic [3:0] i_nparam = 4'd0;
  logic [7:0] i_param = 8'd0;
  logic       i_param_valid = 1'b0;
  logic       o_param_ready;
  logic [7:0] o_data;
  logic       o_we;
  logic       i_done;
  logic       o_dc, o_busy, o_done, o_err;
  logic       done_ser = 1'b0;
  logic       done_inj = 1'b0;

  assign i_done = done_ser | done_inj;

  always #5 clk = ~clk;

  lcd_cmd_seq #(.MAX_PARAM(MAXP), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_cmd(i_cmd),
    .i_nparam(i_nparam), .i_param(i_param), .i_param_valid(i_param_valid),
    .o_param_ready(o_param_ready), .o_data(o_data), .o_we(o_we), .i_done(i_done),
    .o_dc(o_dc), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // cycle bookkeeping and input-side events, sampled at the active edge
  int cyc = 0, idone_n = 0, idone_cyc = -1, acc_n = 0;
  always @(posedge clk) begin
    if (i_done) begin idone_n++; idone_cyc = cyc; end
    if (i_param_valid && o_param_ready) acc_n++;
    cyc++;
  end

  // output monitor
  logic [8:0] obs_byte [0:511];
  int         obs_cyc  [0:511];
  int  obs_n = 0, done_n = 0, done_cyc = 0, err_n = 0, err_cyc = 0, err_busy = 0, stab_viol = 0;
  logic       pend = 1'b0;
  logic [8:0] pend_val = 9'd0;
  int         pend_idn = 0;
  always @(negedge clk) begin
    if (o_we) begin
      if (obs_n < 512) begin obs_byte[obs_n] = {o_dc, o_data}; obs_cyc[obs_n] = cyc; end
      obs_n++;
      pend = 1'b1; pend_val = {o_dc, o_data}; pend_idn = idone_n;
    end else if (pend) begin
      if (idone_n != pend_idn || !rst_n) pend = 1'b0;
      else if ({o_dc, o_data} !== pend_val) stab_viol++;
    end
    if (o_done) begin done_n++; done_cyc = cyc; end
    if (o_err) begin err_n++; err_cyc = cyc; err_busy = int'(o_busy); end
  end

  // serializer model: i_done ser_delay cycles after o_we (0 = never)
  int ser_delay = 12, ser_cnt = 0;
  always @(negedge clk) begin
    done_ser = 1'b0;
    if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) done_ser = 1'b1;
    end
    if (o_we && ser_delay > 0) ser_cnt = ser_delay;
  end

  // parameter source with an optional stall before one byte
  logic [7:0] feed [0:15];
  int feed_n = 0, acc_base = 0, hold_idx = -1, hold_cycles = 0, txn_id = 0;
  int fd_txn = -1, hold_left = 0, fidx = 0;
  logic hold_armed = 1'b0;
  always @(negedge clk) begin
    fidx = acc_n - acc_base;
    if (fd_txn != txn_id) begin fd_txn = txn_id; hold_armed = 1'b0; end
    if (fidx == hold_idx && !hold_armed) begin hold_armed = 1'b1; hold_left = hold_cycles; end
    if (fidx == hold_idx && hold_left > 0) begin
      i_param_valid = 1'b0; hold_left--;
    end else if (fidx >= 0 && fidx < feed_n && fidx < 16) begin
      i_param_valid = 1'b1; i_param = feed[fidx];
    end else begin
      i_param_valid = 1'b0;
    end
  end

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) feed[k] = 8'($urandom);
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int np, input int delay, input int hidx,
                         input int hcyc, input bit inj_start, input bit exp_err);
    int base, d0, e0, s0, sc, n_exp, waited, n_got;
    bit injd;
    logic [8:0] exp_b [0:15];
    ser_delay = delay; hold_idx = hidx; hold_cycles = hcyc;
    feed_n = np; acc_base = acc_n; txn_id++;
    base = obs_n; d0 = done_n; e0 = err_n; s0 = stab_viol; injd = 1'b0;
    n_exp = exp_err ? 1 : 1 + ((np > MAXP) ? MAXP : np);
    exp_b[0] = {1'b0, cmd};
    for (int k = 1; k < 16; k++) exp_b[k] = {1'b1, feed[k-1]};
    i_cmd = cmd; i_nparam = 4'(np); i_start = 1'b1; sc = cyc;
    @(negedge clk); #1;
    i_start = 1'b0; i_cmd = 8'($urandom); i_nparam = 4'($urandom);
    waited = 0;
    while (done_n == d0 && err_n == e0 && waited < 3000) begin
      @(negedge clk); #1; waited++;
      if (inj_start && !injd && obs_n - base == 2) begin i_start = 1'b1; injd = 1'b1; end
      else i_start = 1'b0;
    end
    i_start = 1'b0;
    check_val("txn_end_bound", int'(waited < 3000), 1);
    if (exp_err) begin
      check_val("err_count", err_n - e0, 1);
      check_val("done_absent", done_n - d0, 0);
      if (obs_n > base) check_val("err_latency", err_cyc - obs_cyc[base], TMO);
      check_val("busy_at_err", err_busy, 0);
    end else begin
      check_val("done_count", done_n - d0, 1);
      check_val("err_absent", err_n - e0, 0);
      check_val("done_latency", done_cyc - idone_cyc, 1);
    end
    if (obs_n > base) check_val("we_latency", obs_cyc[base] - sc, 2);
    repeat (3) @(negedge clk);
    #1;
    n_got = obs_n - base;
    check_val("byte_count", n_got, n_exp);
    for (int k = 0; k < 16; k++)
      if (k < n_got && k < n_exp) check_val($sformatf("byte%0d", k), obs_byte[base+k], exp_b[k]);
    check_val("data_stable", stab_viol - s0, 0);
    check_val("idle_busy", o_busy, 0);
    check_val("no_extra_pulse", (done_n - d0) + (err_n - e0), 1);
    $display("TXN %0d cmd=0x%02h nparam=%0d delay=%0d bytes=%0d done=%0d err=%0d",
             txn_id, cmd, np, delay, n_got, done_n - d0, err_n - e0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, d0, e0, w, np;
    fill_rand();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_we", o_we, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_err", o_err, 0);
    check_val("rst_ready", o_param_ready, 0);
    check_val("rst_dc", o_dc, 0);
    check_val("rst_data", o_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // command with four parameters
    feed[0] = 8'h00; feed[1] = 8'h00; feed[2] = 8'h00; feed[3] = 8'hEF;
    run_txn(8'h2A, 4, 12, -1, 0, 1'b0, 1'b0);
    // command only
    run_txn(8'h11, 0, 12, -1, 0, 1'b0, 1'b0);
    // parameter source stalls 50 cycles before the second byte
    fill_rand();
    run_txn(8'h3C, 2, 12, 1, 50, 1'b0, 1'b0);
    // serializer never answers; then answers exactly one cycle too late
    run_txn(8'h29, 3, 0, -1, 0, 1'b0, 1'b1);
    run_txn(8'h2B, 2, TMO, -1, 0, 1'b0, 1'b1);
    // completion on the last allowed cycle
    fill_rand();
    run_txn(8'h36, 2, TMO - 1, -1, 0, 1'b0, 1'b0);

    // stray i_done while idle
    base = obs_n; d0 = done_n; e0 = err_n;
    done_inj = 1'b1; @(negedge clk); #1; done_inj = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("idle_done_busy", o_busy, 0);
    check_val("idle_done_pulses", (obs_n - base) + (done_n - d0) + (err_n - e0), 0);
    // i_start during WAIT_PAR
    fill_rand();
    run_txn(8'h2C, 3, 10, -1, 0, 1'b1, 1'b0);
    // parameter count saturation
    fill_rand();
    run_txn(8'hB1, 15, 3, -1, 0, 1'b0, 1'b0);
    run_txn(8'hB2, MAXP + 1, 2, -1, 0, 1'b0, 1'b0);
    run_txn(8'hB3, MAXP, 1, -1, 0, 1'b0, 1'b0);

    // reset during WAIT_PAR of the second parameter byte
    fill_rand();
    ser_delay = 12; hold_idx = -1; feed_n = 4; acc_base = acc_n; txn_id++;
    base = obs_n; d0 = done_n; e0 = err_n;
    i_cmd = 8'h2C; i_nparam = 4'd4; i_start = 1'b1;
    @(negedge clk); #1; i_start = 1'b0;
    w = 0;
    while (obs_n - base < 3 && w < 500) begin @(negedge clk); #1; w++; end
    check_val("reach_par2_bound", int'(w < 500), 1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_we", o_we, 0);
    check_val("arst_busy", o_busy, 0);
    check_val("arst_dc", o_dc, 0);
    check_val("arst_data", o_data, 0);
    check_val("arst_ready", o_param_ready, 0);
    check_val("arst_done_err", {o_done, o_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_val("post_rst_pulses", (done_n - d0) + (err_n - e0), 0);
    fill_rand();
    run_txn(8'h2A, 4, 12, -1, 0, 1'b0, 1'b0);

    // randomized transactions
    for (int t = 0; t < 20; t++) begin
      fill_rand();
      np = int'($urandom_range(0, 15));
      run_txn(8'($urandom), np, int'($urandom_range(1, TMO - 1)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 20)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
